// File: rtl/eth_rx_field_sequencer_if.sv
// GMII receive side and parsed byte-stream side of the RX field sequencer.
// The slave modport belongs to the sequencer; the master drives GMII and observes.
interface eth_rx_field_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic [7:0]       byte_o;
    logic             byte_valid_o;
    logic             sof_o;
    logic             dst_mac_en_o;
    logic             src_mac_en_o;
    logic             ethertype_en_o;
    logic             hdr_done_o;
    logic             payload_valid_o;
    logic             eof_o;
    logic             frame_err_o;
    logic [CNT_W-1:0] byte_cnt_o;

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output byte_o, byte_valid_o, sof_o,
        output dst_mac_en_o, src_mac_en_o, ethertype_en_o,
        output hdr_done_o, payload_valid_o, eof_o,
        output frame_err_o, byte_cnt_o
    );

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  byte_o, byte_valid_o, sof_o,
        input  dst_mac_en_o, src_mac_en_o, ethertype_en_o,
        input  hdr_done_o, payload_valid_o, eof_o,
        input  frame_err_o, byte_cnt_o
    );
endinterface

// File: rtl/eth_rx_field_sequencer.sv
// GMII RX front end: strips preamble/SFD, tracks frame offset and
// emits a registered byte stream with per-field enable strobes.
module eth_rx_field_sequencer #(
    parameter int PREAMBLE_MAX  = 7,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int CNT_W         = 16
) (
    input logic clk,
    input logic rst,
    eth_rx_field_sequencer_if.slave bus
);
    localparam int PW = $clog2(PREAMBLE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, HEADER, PAYLOAD, DROP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] off, off_n;
    logic [CNT_W-1:0] cnt_n;
    logic [PW-1:0]    pre_cnt, pre_n;
    logic             armed;
    logic [7:0]       byte_n;
    logic             bv_n, sof_n, dst_n, src_n, et_n;
    logic             hd_n, pv_n, eof_n, err_n;

    logic       dv, er;
    logic [7:0] rxd;
    assign dv  = bus.gmii_rx_dv;
    assign er  = bus.gmii_rx_er;
    assign rxd = bus.gmii_rxd;

    always_comb begin
        state_n = state;
        off_n   = off;
        pre_n   = pre_cnt;
        cnt_n   = bus.byte_cnt_o;
        byte_n  = 8'h00;
        bv_n    = 1'b0;
        sof_n   = 1'b0;
        dst_n   = 1'b0;
        src_n   = 1'b0;
        et_n    = 1'b0;
        hd_n    = 1'b0;
        pv_n    = 1'b0;
        eof_n   = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                // armed stays low after reset until dv drops, so a frame
                // cut by reset is ignored instead of flagged
                if (dv && armed) begin
                    unique case (1'b1)
                        er: begin
                            state_n = DROP;
                            err_n   = 1'b1;
                        end
                        rxd == 8'h55: begin
                            state_n = PREAMBLE;
                            pre_n   = PW'(1);
                        end
                        rxd == 8'hD5: begin
                            state_n = HEADER;
                            off_n   = '0;
                            cnt_n   = '0;
                        end
                        default: begin
                            state_n = DROP;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            PREAMBLE: begin
                unique case (1'b1)
                    !dv: state_n = IDLE;
                    er: begin
                        state_n = DROP;
                        err_n   = 1'b1;
                    end
                    rxd == 8'h55: begin
                        if (pre_cnt == PW'(PREAMBLE_MAX)) begin
                            state_n = DROP;
                            err_n   = 1'b1;
                        end else begin
                            pre_n = pre_cnt + PW'(1);
                        end
                    end
                    rxd == 8'hD5: begin
                        state_n = HEADER;
                        off_n   = '0;
                        cnt_n   = '0;
                    end
                    default: begin
                        state_n = DROP;
                        err_n   = 1'b1;
                    end
                endcase
            end
            HEADER: begin
                unique case (1'b1)
                    !dv: begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        eof_n   = 1'b1;
                    end
                    er: begin
                        state_n = DROP;
                        err_n   = 1'b1;
                        eof_n   = 1'b1;
                    end
                    default: begin
                        byte_n = rxd;
                        bv_n   = 1'b1;
                        cnt_n  = off;
                        sof_n  = (off == '0);
                        dst_n  = (off < CNT_W'(6));
                        src_n  = (off >= CNT_W'(6)) && (off < CNT_W'(12));
                        et_n   = (off >= CNT_W'(12));
                        off_n  = off + CNT_W'(1);
                        if (off == CNT_W'(13)) begin
                            hd_n    = 1'b1;
                            state_n = PAYLOAD;
                        end
                    end
                endcase
            end
            PAYLOAD: begin
                unique case (1'b1)
                    !dv: begin
                        state_n = IDLE;
                        eof_n   = 1'b1;
                    end
                    er || (off >= CNT_W'(MAX_FRAME_LEN)): begin
                        state_n = DROP;
                        err_n   = 1'b1;
                        eof_n   = 1'b1;
                    end
                    default: begin
                        byte_n = rxd;
                        bv_n   = 1'b1;
                        pv_n   = 1'b1;
                        cnt_n  = off;
                        off_n  = off + CNT_W'(1);
                    end
                endcase
            end
            DROP: begin
                if (!dv) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            off                 <= '0;
            pre_cnt             <= '0;
            armed               <= 1'b0;
            bus.byte_o          <= 8'h00;
            bus.byte_valid_o    <= 1'b0;
            bus.sof_o           <= 1'b0;
            bus.dst_mac_en_o    <= 1'b0;
            bus.src_mac_en_o    <= 1'b0;
            bus.ethertype_en_o  <= 1'b0;
            bus.hdr_done_o      <= 1'b0;
            bus.payload_valid_o <= 1'b0;
            bus.eof_o           <= 1'b0;
            bus.frame_err_o     <= 1'b0;
            bus.byte_cnt_o      <= '0;
        end else begin
            state               <= state_n;
            off                 <= off_n;
            pre_cnt             <= pre_n;
            armed               <= armed | ~dv;
            bus.byte_o          <= byte_n;
            bus.byte_valid_o    <= bv_n;
            bus.sof_o           <= sof_n;
            bus.dst_mac_en_o    <= dst_n;
            bus.src_mac_en_o    <= src_n;
            bus.ethertype_en_o  <= et_n;
            bus.hdr_done_o      <= hd_n;
            bus.payload_valid_o <= pv_n;
            bus.eof_o           <= eof_n;
            bus.frame_err_o     <= err_n;
            bus.byte_cnt_o      <= cnt_n;
        end
    end
endmodule

// File: tb/tb_eth_rx_field_sequencer.sv
// Directed vector bench for eth_rx_field_sequencer: per-cycle GMII
// inputs with hand-derived output flags, offsets and bytes.
module tb_eth_rx_field_sequencer;
    localparam bit [8:0] F_BV  = 9'h100;
    localparam bit [8:0] F_SOF = 9'h080;
    localparam bit [8:0] F_DST = 9'h040;
    localparam bit [8:0] F_SRC = 9'h020;
    localparam bit [8:0] F_ET  = 9'h010;
    localparam bit [8:0] F_HD  = 9'h008;
    localparam bit [8:0] F_PV  = 9'h004;
    localparam bit [8:0] F_EOF = 9'h002;
    localparam bit [8:0] F_ERR = 9'h001;

    typedef struct {
        int        tid;
        bit        rst;
        bit        dv;
        bit        er;
        bit [7:0]  rxd;
        bit [7:0]  byt;
        bit [8:0]  f;
        bit [15:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    vec_t vq[$];
    bit [15:0] exp_cnt;
    bit [7:0]  hb[14];
    int        tid;
    int        nvec;
    int        nerr;
    bit        done;

    eth_rx_field_sequencer_if #(.CNT_W(16)) bus();

    eth_rx_field_sequencer #(
        .PREAMBLE_MAX(7),
        .MAX_FRAME_LEN(1522),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        done = 1'b0;
        #200000;
        if (!done) begin
            $display("FAIL: timeout waiting for vector playback to finish");
            $display("== TEST FAILED ==");
            $finish;
        end
    end

    function automatic void add(bit r, bit d, bit e, bit [7:0] x,
                                bit [7:0] b, bit [8:0] f);
        vec_t v;
        v.tid = tid;
        v.rst = r;
        v.dv  = d;
        v.er  = e;
        v.rxd = x;
        v.byt = b;
        v.f   = f;
        v.cnt = exp_cnt;
        vq.push_back(v);
    endfunction

    function automatic void inbyte(bit [7:0] x);
        add(1'b0, 1'b1, 1'b0, x, 8'h00, 9'h000);
    endfunction

    function automatic void pre(int n);
        for (int i = 0; i < n; i++) inbyte(8'h55);
    endfunction

    function automatic void sfd();
        exp_cnt = 16'd0;
        inbyte(8'hD5);
    endfunction

    function automatic void hdr(int o);
        bit [8:0] f;
        f = F_BV;
        if (o == 0) f |= F_SOF;
        if (o < 6) f |= F_DST;
        else if (o < 12) f |= F_SRC;
        else f |= F_ET;
        if (o == 13) f |= F_HD;
        exp_cnt = 16'(o);
        add(1'b0, 1'b1, 1'b0, hb[o], hb[o], f);
    endfunction

    function automatic void pay(int o, bit [7:0] b);
        exp_cnt = 16'(o);
        add(1'b0, 1'b1, 1'b0, b, b, F_BV | F_PV);
    endfunction

    function automatic void gap(bit [8:0] f);
        add(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, f);
    endfunction

    function automatic void good(int npre, int npay);
        pre(npre);
        sfd();
        for (int o = 0; o < 14; o++) hdr(o);
        for (int i = 0; i < npay; i++) pay(14 + i, 8'(i + 1));
        gap(F_EOF);
    endfunction

    initial begin
        bit [8:0]  af;
        bit        ok;
        vec_t      v;
        hb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
               8'h08, 8'h00};
        nvec    = 0;
        nerr    = 0;
        exp_cnt = 16'd0;

        tid = 0;
        add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 9'h000);
        add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 9'h000);
        gap(9'h000);
        gap(9'h000);
        pre(3);
        gap(9'h000);

        tid = 1;
        good(7, 46);

        tid = 2;
        pre(7);
        sfd();
        for (int o = 0; o < 8; o++) hdr(o);
        add(1'b0, 1'b1, 1'b1, hb[8], 8'h00, F_ERR | F_EOF);
        for (int o = 9; o < 14; o++) inbyte(hb[o]);
        for (int i = 0; i < 5; i++) inbyte(8'h77);
        gap(9'h000);
        good(7, 46);

        tid = 3;
        pre(7);
        sfd();
        for (int o = 0; o < 11; o++) hdr(o);
        gap(F_ERR | F_EOF);
        good(7, 46);

        tid = 4;
        pre(7);
        add(1'b0, 1'b1, 1'b0, 8'h55, 8'h00, F_ERR);
        inbyte(8'hD5);
        for (int o = 0; o < 14; o++) inbyte(hb[o]);
        gap(9'h000);
        good(1, 46);
        good(0, 46);

        tid = 5;
        pre(7);
        sfd();
        for (int o = 0; o < 14; o++) hdr(o);
        for (int o = 14; o < 1522; o++) pay(o, 8'(o));
        add(1'b0, 1'b1, 1'b0, 8'hEE, 8'h00, F_ERR | F_EOF);
        for (int i = 0; i < 7; i++) inbyte(8'hEE);
        gap(9'h000);

        tid = 6;
        pre(7);
        sfd();
        for (int o = 0; o < 14; o++) hdr(o);
        for (int i = 0; i < 10; i++) pay(14 + i, 8'(i + 1));
        exp_cnt = 16'd0;
        add(1'b1, 1'b1, 1'b0, 8'h0B, 8'h00, 9'h000);
        for (int i = 0; i < 5; i++) inbyte(8'h33);
        gap(9'h000);
        good(7, 46);

        rst            = 1'b1;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        af = {bus.byte_valid_o, bus.sof_o, bus.dst_mac_en_o,
              bus.src_mac_en_o, bus.ethertype_en_o, bus.hdr_done_o,
              bus.payload_valid_o, bus.eof_o, bus.frame_err_o};
        nvec++;
        if (af !== 9'h000 || bus.byte_cnt_o !== 16'd0 ||
            bus.byte_o !== 8'h00) begin
            nerr++;
            $display("FAIL reset: flags=%b cnt=%0d byte=%h, want all zero",
                     af, bus.byte_cnt_o, bus.byte_o);
        end
        #3;

        for (int i = 0; i < vq.size(); i++) begin
            v              = vq[i];
            rst            = v.rst;
            bus.gmii_rx_dv = v.dv;
            bus.gmii_rx_er = v.er;
            bus.gmii_rxd   = v.rxd;
            @(posedge clk);
            #1;
            af = {bus.byte_valid_o, bus.sof_o, bus.dst_mac_en_o,
                  bus.src_mac_en_o, bus.ethertype_en_o, bus.hdr_done_o,
                  bus.payload_valid_o, bus.eof_o, bus.frame_err_o};
            ok = (af === v.f) && (bus.byte_cnt_o === v.cnt);
            if (v.f[8] || v.rst) ok = ok && (bus.byte_o === v.byt);
            nvec++;
            if (!ok) begin
                nerr++;
                $display("FAIL t%0d vec %0d: got flags=%b cnt=%0d byte=%h, want flags=%b cnt=%0d byte=%h",
                         v.tid, i, af, bus.byte_cnt_o, bus.byte_o,
                         v.f, v.cnt, v.byt);
            end
            #3;
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        if (nerr == 0) $display("== TEST PASSED ==");
        else $display("== TEST FAILED ==");
        $finish;
    end
endmodule
